// File: rtl/ws2812b_frame_scheduler.sv
// ws2812b_frame_scheduler
//   Shares one WS2812B strip between NREQ frame sources. A round-robin arbiter
//   grants one requester and latches its N-bit on/off pattern and its 24-bit GRB
//   colour. The block then streams one 24-bit word per LED, LED N-1 first, to the
//   bit serialiser over valid/ready. After the last word the line is held idle for
//   LATCH_CYCLES clocks, frame_done pulses, and arbitration resumes.
//
// Optional feature: define WS2812B_DIM_EN to add the 3-bit `dim` input and the
//   DIM_RESET parameter. Each G/R/B byte is shifted right by the dim value that was
//   sampled at grant time.
//
// Ports
//   clk_50      in   clock
//   rst_n       in   asynchronous active-low reset
//   req         in   [NREQ]      level requests, held until the matching gnt pulse
//   frame_in    in   [NREQ*N]    source i pattern at [i*N +: N], bit k lights LED k
//   colour_in   in   [NREQ*24]   source i GRB colour at [i*24 +: 24]
//   dim         in   [3]         (WS2812B_DIM_EN only) brightness shift
//   gnt         out  [NREQ]      one-hot, one-cycle grant pulse
//   busy        out              high from the gnt cycle through the frame_done cycle
//   pix_data    out  [24]        GRB word of the current LED
//   pix_valid   out              pix_data valid
//   pix_ready   in               serialiser accepts the word when valid && ready
//   frame_done  out              one-cycle pulse at the end of the latch gap
module ws2812b_frame_scheduler #(
  parameter int N            = 32,
  parameter int NREQ         = 4,
  parameter int LATCH_CYCLES = 25000
`ifdef WS2812B_DIM_EN
  , parameter logic [2:0] DIM_RESET = 3'd0
`endif
) (
  input  logic                 clk_50,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*N-1:0]    frame_in,
  input  logic [NREQ*24-1:0]   colour_in,
`ifdef WS2812B_DIM_EN
  input  logic [2:0]           dim,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [23:0]          pix_data,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 frame_done
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(LATCH_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_LATCH} state_t;

  // Registered state
  state_t             r_state;
  logic [PW-1:0]      r_ptr;
  logic [IW-1:0]      r_idx;
  logic [CW-1:0]      r_cnt;
  logic [N-1:0]       r_frame;
  logic [23:0]        r_colour;
  logic [NREQ-1:0]    r_gnt;
  logic               r_busy;
  logic [23:0]        r_pix_data;
  logic               r_pix_valid;
  logic               r_frame_done;
`ifdef WS2812B_DIM_EN
  logic [2:0]         r_dim;
`endif

  // Next-state values
  state_t             w_state_nxt;
  logic [PW-1:0]      w_ptr_nxt;
  logic [IW-1:0]      w_idx_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [NREQ-1:0]    w_gnt_nxt;
  logic               w_busy_nxt;
  logic [23:0]        w_pix_data_nxt;
  logic               w_pix_valid_nxt;
  logic               w_frame_done_nxt;
  logic               w_load;

  // Arbiter results
  logic               w_found;
  logic [PW-1:0]      w_gidx;
  logic [N-1:0]       w_sel_frame;
  logic [23:0]        w_sel_colour;
  logic [23:0]        w_colour_eff;
  logic [IW-1:0]      w_idx_dec;

  // Round-robin search: first set request strictly after the last winner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!w_found && req[(int'(r_ptr) + off) % NREQ]) begin
        w_found = 1'b1;
        w_gidx  = PW'((int'(r_ptr) + off) % NREQ);
      end
    end
  end

  assign w_sel_frame  = frame_in[int'(w_gidx)*N +: N];
  assign w_sel_colour = colour_in[int'(w_gidx)*24 +: 24];
  assign w_idx_dec    = r_idx - IW'(1);

`ifdef WS2812B_DIM_EN
  // Each channel is dimmed independently so no bits bleed between G, R and B.
  assign w_colour_eff = {r_colour[23:16] >> r_dim,
                         r_colour[15:8]  >> r_dim,
                         r_colour[7:0]   >> r_dim};
`else
  assign w_colour_eff = r_colour;
`endif

  // Next-state / output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_gnt_nxt        = '0;
    w_busy_nxt       = r_busy;
    w_pix_data_nxt   = r_pix_data;
    w_pix_valid_nxt  = r_pix_valid;
    w_frame_done_nxt = 1'b0;
    w_load           = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // The frame_done cycle is spent here, so a pending request is granted
        // on the very next edge.
        w_busy_nxt      = 1'b0;
        w_pix_valid_nxt = 1'b0;
        w_pix_data_nxt  = 24'h0;
        if (w_found) begin
          w_gnt_nxt   = NREQ'(1) << w_gidx;
          w_busy_nxt  = 1'b1;
          w_load      = 1'b1;
          w_ptr_nxt   = w_gidx;
          w_idx_nxt   = IW'(N - 1);
          w_state_nxt = S_STREAM;
        end
      end

      S_STREAM: begin
        if (!r_pix_valid) begin
          // Grant cycle: the pattern is latched now, present the first word.
          w_pix_valid_nxt = 1'b1;
          w_pix_data_nxt  = r_frame[r_idx] ? w_colour_eff : 24'h0;
        end else if (pix_ready) begin
          if (r_idx == '0) begin
            w_pix_valid_nxt = 1'b0;
            w_pix_data_nxt  = 24'h0;
            w_cnt_nxt       = '0;
            w_state_nxt     = S_LATCH;
          end else begin
            w_idx_nxt      = w_idx_dec;
            w_pix_data_nxt = r_frame[w_idx_dec] ? w_colour_eff : 24'h0;
          end
        end
      end

      S_LATCH: begin
        w_pix_valid_nxt = 1'b0;
        w_pix_data_nxt  = 24'h0;
        if (r_cnt == CW'(LATCH_CYCLES - 1)) begin
          w_frame_done_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_busy_nxt      = 1'b0;
        w_pix_valid_nxt = 1'b0;
        w_pix_data_nxt  = 24'h0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= PW'(NREQ - 1);
      r_idx        <= IW'(N - 1);
      r_cnt        <= '0;
      r_frame      <= '0;
      r_colour     <= 24'h0;
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_pix_data   <= 24'h0;
      r_pix_valid  <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef WS2812B_DIM_EN
      r_dim        <= DIM_RESET;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_busy       <= w_busy_nxt;
      r_pix_data   <= w_pix_data_nxt;
      r_pix_valid  <= w_pix_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (w_load) begin
        r_frame  <= w_sel_frame;
        r_colour <= w_sel_colour;
`ifdef WS2812B_DIM_EN
        r_dim    <= dim;
`endif
      end
    end
  end

  assign gnt        = r_gnt;
  assign busy       = r_busy;
  assign pix_data   = r_pix_data;
  assign pix_valid  = r_pix_valid;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ws2812b_frame_scheduler.sv
// Directed bench for ws2812b_frame_scheduler with N=4, NREQ=4, LATCH_CYCLES=10.
module tb_ws2812b_frame_scheduler;
  localparam int N    = 4;
  localparam int NREQ = 4;
  localparam int LC   = 10;

  logic          clk_50 = 1'b0;
  logic          rst_n  = 1'b0;
  logic [3:0]    req    = '0;
  logic [15:0]   frame_in  = '0;
  logic [95:0]   colour_in = '0;
  logic          pix_ready = 1'b1;
  logic [3:0]    gnt;
  logic          busy;
  logic [23:0]   pix_data;
  logic          pix_valid;
  logic          frame_done;
`ifdef WS2812B_DIM_EN
  logic [2:0]    dim = 3'd0;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  ws2812b_frame_scheduler #(.N(N), .NREQ(NREQ), .LATCH_CYCLES(LC)) dut (
    .clk_50(clk_50), .rst_n(rst_n), .req(req), .frame_in(frame_in),
    .colour_in(colour_in),
`ifdef WS2812B_DIM_EN
    .dim(dim),
`endif
    .gnt(gnt), .busy(busy), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .frame_done(frame_done));

  always #5 clk_50 = ~clk_50;

  typedef struct packed {
    logic [1:0]        src;
    logic [3:0]        req;
    logic [3:0]        frame;
    logic [23:0]       colour;
    logic [3:0]        egnt;
    logic [0:3][23:0]  words;   // words[0] is the first word on the wire (LED 3)
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk_50); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic set_src(input int s, input logic [3:0] f, input logic [23:0] c);
    frame_in[s*4 +: 4]   = f;
    colour_in[s*24 +: 24] = c;
  endtask

  task automatic wait_gnt(input logic [3:0] eg, input string nm);
    int c = 0;
    do begin step(); c++; end while (gnt == 4'b0 && c < 30);
    chk(nm, 32'({busy, pix_valid, gnt}), 32'({1'b1, 1'b0, eg}));
  endtask

  // Grant, four words, latch gap, frame_done. Returns at the frame_done sample.
  task automatic run_frame(input logic [3:0] eg, input logic [0:3][23:0] w,
                           input bit stall, input bit hold, input string nm);
    int got = 0, held = 0, bad = 0;
    pix_ready = 1'b1;
    wait_gnt(eg, {nm, "_gnt"});
    if (!hold) begin
      req       = req & ~eg;
      frame_in  = ~frame_in;    // must not disturb the latched frame
      colour_in = ~colour_in;
    end
    for (int c = 0; c < 40 && got < 4; c++) begin
      step();
      if (pix_valid) begin
        if (pix_data !== w[got]) bad++;
        if (stall && got == 1 && held < 5) begin pix_ready = 1'b0; held++; end
        else begin pix_ready = 1'b1; got++; end
      end else bad++;
    end
    chk({nm, "_words"}, 32'(bad), 32'd0);
    chk({nm, "_count"}, 32'(got), 32'd4);
    bad = 0;
    for (int i = 0; i < LC; i++) begin
      step();
      if (pix_valid || frame_done || pix_data != 24'h0 || !busy) bad++;
    end
    chk({nm, "_latch"}, 32'(bad), 32'd0);
    step();
    chk({nm, "_done"}, 32'({frame_done, busy, pix_valid}), 32'b110);
  endtask

  initial begin
    tbl[0] = '{src:2'd1, req:4'b0010, frame:4'b1010, colour:24'h00FF00, egnt:4'b0010,
               words:{24'h00FF00, 24'h0, 24'h00FF00, 24'h0}};
    tbl[1] = '{src:2'd3, req:4'b1000, frame:4'b0111, colour:24'h123456, egnt:4'b1000,
               words:{24'h0, 24'h123456, 24'h123456, 24'h123456}};
    tbl[2] = '{src:2'd0, req:4'b0001, frame:4'b1111, colour:24'hABCDEF, egnt:4'b0001,
               words:{24'hABCDEF, 24'hABCDEF, 24'hABCDEF, 24'hABCDEF}};
    tbl[3] = '{src:2'd2, req:4'b0101, frame:4'b0001, colour:24'h0000FF, egnt:4'b0100,
               words:{24'h0, 24'h0, 24'h0, 24'h0000FF}};
    tbl[4] = '{src:2'd0, req:4'b0001, frame:4'b0000, colour:24'hFFFFFF, egnt:4'b0001,
               words:{24'h0, 24'h0, 24'h0, 24'h0}};

    // Reset state
    #2;
    chk("reset_outputs", 32'({gnt, busy, pix_valid, frame_done, pix_data}), 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("idle_no_req", 32'({gnt, busy, pix_valid, frame_done, pix_data}), 32'd0);

    // Table-driven single-source frames
    for (int i = 0; i < 5; i++) begin
      req       = tbl[i].req;
      frame_in  = '0;
      colour_in = '1;
      set_src(int'(tbl[i].src), tbl[i].frame, tbl[i].colour);
      run_frame(tbl[i].egnt, tbl[i].words, 1'b0, 1'b0, $sformatf("vec%0d", i));
    end
    step();
    chk("idle_after_done", 32'({gnt, busy, pix_valid, frame_done}), 32'd0);

    // Backpressure on the second word
    frame_in = '0; colour_in = '0;
    set_src(1, 4'b1010, 24'h00FF00);
    req = 4'b0010;
    run_frame(4'b0010, {24'h00FF00, 24'h0, 24'h00FF00, 24'h0}, 1'b1, 1'b0, "bp");

    // Round robin with every request held
    rst_n = 1'b0; step(); rst_n = 1'b1;
    for (int s = 0; s < 4; s++) set_src(s, 4'b1111, 24'h111111 * 24'(s + 1));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [23:0] c;
      c = 24'h111111 * 24'((k % 4) + 1);
      run_frame(4'b0001 << (k % 4), {c, c, c, c}, 1'b0, 1'b1, $sformatf("rr%0d", k));
    end
    req = 4'b0000;
    step();

    // Asynchronous reset during word 2
    frame_in = '0; colour_in = '0;
    set_src(0, 4'b1111, 24'h777777);
    req = 4'b0001;
    wait_gnt(4'b0001, "mid_gnt");
    req = 4'b0000;
    step(); step();
    chk("mid_word2", 32'({pix_valid, pix_data}), 32'({1'b1, 24'h777777}));
    #3 rst_n = 1'b0;
    #1 chk("async_reset", 32'({gnt, busy, pix_valid, frame_done, pix_data}), 32'd0);
    set_src(1, 4'b1100, 24'h0000AA);
    set_src(2, 4'b0000, 24'hFFFFFF);
    req = 4'b0110;
    step();
    rst_n = 1'b1;
    run_frame(4'b0010, {24'h0000AA, 24'h0000AA, 24'h0, 24'h0}, 1'b0, 1'b0, "post_rst");
    run_frame(4'b0100, {24'h0, 24'h0, 24'h0, 24'h0}, 1'b0, 1'b0, "post_rst2");

    // Late request during LATCH, plus a dropped pulse that must be lost
    set_src(0, 4'b1111, 24'h010203);
    req = 4'b0001;
    wait_gnt(4'b0001, "late_src0");
    req = 4'b0000;
    repeat (4) step();
    for (int i = 0; i < LC; i++) begin
      step();
      if (i == 2) req[2] = 1'b1;
      if (i == 3) req[2] = 1'b0;
      if (i == 5) req[3] = 1'b1;
    end
    step();
    chk("late_done", 32'(frame_done), 32'd1);
    step();
    chk("late_gnt", 32'(gnt), 32'b1000);
    req = 4'b0000;
    begin
      int stray = 0, dones = 0;
      for (int c = 0; c < 60; c++) begin
        step();
        if (gnt != 4'b0) stray++;
        if (frame_done) dones++;
      end
      chk("lost_pulse", 32'(stray), 32'd0);
      chk("late_one_done", 32'(dones), 32'd1);
    end

`ifdef WS2812B_DIM_EN
    set_src(0, 4'b1111, 24'hFF8040);
    dim = 3'd2; req = 4'b0001;
    run_frame(4'b0001, {24'h3F2010, 24'h3F2010, 24'h3F2010, 24'h3F2010}, 1'b0, 1'b0, "dim2");
    set_src(1, 4'b1111, 24'hFF8040);
    dim = 3'd0; req = 4'b0010;
    run_frame(4'b0010, {24'hFF8040, 24'hFF8040, 24'hFF8040, 24'hFF8040}, 1'b0, 1'b0, "dim0");
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
